// File: rtl/mdu_pkg.sv
// Shared decode definitions: ALU operation codes and multiply/divide unit
// operation codes, kept together so the decoder and the MDU use one source.
// Also provides small helpers that classify md_op values.
package mdu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMthi  = 3'd5,
    MdMtlo  = 3'd6
  } md_op_e;

  // True for ops that occupy the unit for several cycles.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers.
// Ports:
//   clk    - clock, all state on rising edge
//   reset  - synchronous active-low reset
//   start  - issue pulse for mult/multu/div/divu
//   md_op  - operation select (mdu_pkg::md_op_e)
//   A, B   - rs / rt operands (A also carries mthi/mtlo data)
//   busy   - operation in flight
//   hi, lo - HI and LO registers
// A long op latches its operands, stays busy for a fixed cycle count, then
// commits the result to hi/lo on the edge that ends the last busy cycle.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     a_q, b_q, hi_q, lo_q;
  logic [2:0]      op_q;

  // Product: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are then correct for both signed and unsigned multiply.
  logic        sgn_mul;
  logic [63:0] ext_a, ext_b, prod;

  always_comb begin
    sgn_mul = (op_q == MdMult);
    ext_a   = {{32{sgn_mul & a_q[31]}}, a_q};
    ext_b   = {{32{sgn_mul & b_q[31]}}, b_q};
    prod    = ext_a * ext_b;
  end

  // Quotient/remainder via magnitudes. 0x80000000 / -1 naturally yields
  // quotient 0x80000000 and remainder 0 through the wrap-around negate.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

  always_comb begin
    a_neg   = (op_q == MdDiv) && a_q[31];
    b_neg   = (op_q == MdDiv) && b_q[31];
    a_mag   = a_neg ? (32'd0 - a_q) : a_q;
    b_mag   = b_neg ? (32'd0 - b_q) : b_q;
    // Divide-by-zero result is discarded; keep the divider input defined.
    divisor = (b_q == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MdNone;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // mthi/mtlo win over a concurrent start, which is dropped.
          if (md_op == MdMthi) begin
            hi_q <= A;
          end else if (md_op == MdMtlo) begin
            lo_q <= A;
          end else if (start && md_is_long(md_op)) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= md_op;
            cnt_q   <= md_is_div(md_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            state_q <= StRun;
          end
        end
        StRun: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            if (md_is_div(op_q)) begin
              if (b_q != 32'd0) begin
                hi_q <= rem;
                lo_q <= quot;
              end
            end else begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: issue pulse for mult/multu/div/divu.
REQ-006 SHALL have port md_op, input, 3: operation select (mult, multu, div, divu, mthi, mtlo, none).
REQ-007 SHALL have port A, input, 32: rs operand (dividend, multiplicand, or mthi/mtlo data).
REQ-008 SHALL have port B, input, 32: rt operand (divisor, multiplier).
REQ-009 SHALL have port busy, output, 1: operation in flight.
REQ-010 SHALL have port hi, output, 32: HI register, read by mfhi.
REQ-011 SHALL have port lo, output, 32: LO register, read by mflo.

Function
REQ-012 SHALL have states IDLE and RUN; busy = (state == RUN), registered.
REQ-013 SHALL latch A, B and md_op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN in the same edge when start=1 in IDLE with a mult/div md_op.
REQ-014 SHALL hold busy=1 for exactly N consecutive cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-015 SHALL update hi/lo and return to IDLE on the edge that ends the N-th busy cycle; new values are visible the cycle busy is first 0.
REQ-016 SHALL compute mult as a signed 32x32->64 product and multu as an unsigned product: hi = bits[63:32], lo = bits[31:0].
REQ-017 SHALL compute div/divu as lo = quotient, hi = remainder; the signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-018 SHALL leave hi and lo unchanged when div/divu has B == 0; busy still runs the full DIV_CYCLES.
REQ-019 SHALL define signed div 0x80000000 / 0xFFFFFFFF as lo = 0x80000000, hi = 0.
REQ-020 SHALL ignore start and mthi/mtlo while busy=1; the in-flight operation and its result are unaffected.
REQ-021 SHALL write A to hi (mthi) or lo (mtlo) on the next edge in IDLE, with no busy assertion.
REQ-022 SHALL give mthi/mtlo precedence over start when both arrive in the same IDLE cycle; start is then dropped.
REQ-023 SHALL NOT raise any overflow indication; overflow is not architecturally defined for these ops.
REQ-024 SHALL NOT let hi/lo change during RUN until the completion edge.

Reset
REQ-025 SHALL, on a rising edge with reset=0, set state=IDLE, busy=0, hi=0, lo=0 and the counter to 0.
REQ-026 SHALL abort an in-flight operation when reset asserts mid-RUN: no hi/lo update, busy=0 on the next cycle.
REQ-027 SHALL ignore start in the cycle reset is low.

Structure
REQ-028 SHALL place the md_op encodings in the shared definitions header beside the alu_op codes, so decode logic and mdu use one source.
REQ-029 SHALL be a single module without sub-modules: one counter, one operand/op latch, and inline product/quotient logic.
REQ-030 SHALL size the counter as $clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1 bits.

Verification
REQ-031 SHALL cover: mult A=0xFFFFFFFF, B=0x00000002 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 SHALL cover: div A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu A=7, B=2 -> lo=3, hi=1.
REQ-033 SHALL cover: div with B=0 after mthi 0x12345678 -> busy for 10 cycles, then hi=0x12345678 and lo unchanged.
REQ-034 SHALL cover: a second start and an mtlo issued during mult busy -> both ignored; the mult result lands at cycle 5; lo does not equal the mtlo data.
REQ-035 SHALL cover: reset=0 at busy cycle 3 of a div -> busy=0, hi=lo=0; a start in the following cycle runs normally.
REQ-036 SHALL cover: mtlo and start in the same IDLE cycle -> lo=A, busy stays 0.
